// File: rtl/pll_rst_sequencer_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// State encoding is visible on the debug probe port.
package pll_rst_sequencer_pkg;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  localparam int DEF_N_CH             = 4;
  localparam int DEF_PLL_RST_CYC      = 16;
  localparam int DEF_LOCK_TIMEOUT_CYC = 4096;
  localparam int DEF_LOCK_STABLE_CYC  = 64;
  localparam int DEF_STAGGER_CYC      = 8;
  localparam int DEF_MAX_RETRY        = 3;
  localparam int DEF_CNT_W            = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pll_rst_sequencer_sync_2ff.sv
// Two-flop synchroniser for the asynchronous PLL LOCKED flag.
// Synchronous active-high reset clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/pll_rst_sequencer.sv
// PLL reset driver, lock qualifier and staggered channel reset release.
// Define PLL_RETRY_EN to retry the PLL reset after a lock timeout.
module pll_rst_sequencer
  import pll_rst_sequencer_pkg::*;
#(
  parameter int N_CH             = DEF_N_CH,
  parameter int PLL_RST_CYC      = DEF_PLL_RST_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int STAGGER_CYC      = DEF_STAGGER_CYC,
  parameter int MAX_RETRY        = DEF_MAX_RETRY,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic             CLKIN1_IN,
  input  logic             RST_IN,
  input  logic             LOCKED_IN,
  output logic             PLL_RST_OUT,
  output logic [N_CH-1:0]  CH_RST_OUT,
  output logic             ALL_READY_OUT,
  output logic             TIMEOUT_OUT,
  output logic [CNT_W-1:0] LOCK_LOSS_CNT_OUT,
  output logic [2:0]       STATE_OUT
);

  localparam int IDX_W = clog2(N_CH + 1);

  localparam logic [31:0] PLL_LIM = 32'(PLL_RST_CYC);
  localparam logic [31:0] TO_LIM  = 32'(LOCK_TIMEOUT_CYC);
  localparam logic [31:0] STB_LIM = 32'(LOCK_STABLE_CYC);
  localparam logic [31:0] STG_LIM = 32'(STAGGER_CYC);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(N_CH);

  if (N_CH < 1 || N_CH > 16 || PLL_RST_CYC < 1 ||
      LOCK_TIMEOUT_CYC < 1 || LOCK_STABLE_CYC < 1 ||
      STAGGER_CYC < 1 || MAX_RETRY < 0 ||
      CNT_W < 1) begin : g_bad_param
    $error("pll_rst_sequencer: parameter out of range");
  end

  state_t           state_q, state_d;
  logic [31:0]      tmr_q, tmr_d, tmr_inc;
  logic [IDX_W-1:0] rel_q, rel_d;
  logic [N_CH-1:0]  ch_q, ch_d;
  logic             pll_q, pll_d;
  logic             rdy_q, rdy_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lk;
  logic             loss;
  logic             expire;

`ifdef PLL_RETRY_EN
  localparam int RTY_W =
    (MAX_RETRY < 1) ? 1 : clog2(MAX_RETRY + 1);
  localparam logic [RTY_W-1:0] RTY_LIM = RTY_W'(MAX_RETRY);
  logic [RTY_W-1:0] rty_q, rty_d;
`endif

  sync_2ff u_lock_sync (
    .clk (CLKIN1_IN),
    .rst (RST_IN),
    .d   (LOCKED_IN),
    .q   (lk)
  );

  assign tmr_inc = tmr_q + 32'd1;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rel_d   = rel_q;
    ch_d    = ch_q;
    pll_d   = pll_q;
    rdy_d   = rdy_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    loss    = 1'b0;
    expire  = 1'b0;
`ifdef PLL_RETRY_EN
    rty_d   = rty_q;
`endif

    unique case (state_q)
      S_PLL_RST: begin
        if (tmr_inc >= PLL_LIM) begin
          state_d = S_WAIT_LOCK;
          tmr_d   = '0;
          pll_d   = 1'b0;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_WAIT_LOCK: begin
        if (lk) begin
          state_d = S_STABLE;
          tmr_d   = '0;
        end else if (tmr_inc >= TO_LIM) begin
          expire = 1'b1;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_STABLE: begin
        // A dropout here is a glitch, not a loss: just rearm.
        if (!lk) begin
          state_d = S_WAIT_LOCK;
          tmr_d   = '0;
        end else if (tmr_inc >= STB_LIM) begin
          state_d = S_RELEASE;
          tmr_d   = '0;
          rel_d   = IDX_ONE;
          ch_d[0] = 1'b0;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_RELEASE: begin
        if (!lk) begin
          loss = 1'b1;
        end else if (rel_q == IDX_END) begin
          state_d = S_RUN;
          rdy_d   = 1'b1;
        end else if (tmr_inc >= STG_LIM) begin
          tmr_d = '0;
          rel_d = rel_q + IDX_ONE;
          for (int i = 1; i < N_CH; i++) begin
            if (IDX_W'(i) == rel_q) ch_d[i] = 1'b0;
          end
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_RUN: begin
        if (!lk) loss = 1'b1;
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_PLL_RST;
        tmr_d   = '0;
        pll_d   = 1'b1;
        ch_d    = '1;
        rdy_d   = 1'b0;
      end
    endcase

    unique case (1'b1)
      loss: begin
        state_d = S_PLL_RST;
        tmr_d   = '0;
        pll_d   = 1'b1;
        ch_d    = '1;
        rdy_d   = 1'b0;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`ifdef PLL_RETRY_EN
        rty_d   = '0;
`endif
      end
      expire: begin
`ifdef PLL_RETRY_EN
        if (rty_q < RTY_LIM) begin
          rty_d   = rty_q + 1'b1;
          state_d = S_PLL_RST;
          tmr_d   = '0;
          pll_d   = 1'b1;
        end else begin
          state_d = S_FAIL;
          to_d    = 1'b1;
          pll_d   = 1'b0;
          ch_d    = '1;
        end
`else
        state_d = S_FAIL;
        to_d    = 1'b1;
        pll_d   = 1'b0;
        ch_d    = '1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLKIN1_IN) begin
    if (RST_IN) begin
      state_q <= S_PLL_RST;
      tmr_q   <= '0;
      rel_q   <= '0;
      ch_q    <= '1;
      pll_q   <= 1'b1;
      rdy_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      rel_q   <= rel_d;
      ch_q    <= ch_d;
      pll_q   <= pll_d;
      rdy_q   <= rdy_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PLL_RETRY_EN
  always_ff @(posedge CLKIN1_IN) begin
    if (RST_IN) rty_q <= '0;
    else        rty_q <= rty_d;
  end
`endif

  assign PLL_RST_OUT       = pll_q;
  assign CH_RST_OUT        = ch_q;
  assign ALL_READY_OUT     = rdy_q;
  assign TIMEOUT_OUT       = to_q;
  assign LOCK_LOSS_CNT_OUT = cnt_q;
  assign STATE_OUT         = state_q;

endmodule
